// File: rtl/generator_pkg.sv
// Definitions shared by the sample generator blocks: the loader FSM encoding
// and the default word/address widths used by the sample RAM and its loader.
package generator_pkg;

    localparam int GEN_DATA_WIDTH = 8;
    localparam int GEN_ADDR_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        DONE = ST_DONE
    } loader_state_t;

endpackage

// File: rtl/ram_sp_loader.sv
// Streams valid/ready words into consecutive sample RAM addresses starting at a
// programmed base, and reports completion, beat count and a running checksum.
module ram_sp_loader
    import generator_pkg::*;
#(
    parameter int DATA_WIDTH = GEN_DATA_WIDTH,
    parameter int ADDR_WIDTH = GEN_ADDR_WIDTH,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    loader_state_t         state, state_n;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [CW-1:0]         len_q;
    logic                  beat;
    logic                  start_acc;
    logic                  last_beat;

    // words_written still holds the pre-beat count, so +1 is this beat's number
    assign last_beat = (words_written + CW'(1)) == len_q;
    assign in_ready  = (state == LOAD) && !abort;
    assign busy      = (state == LOAD);
    assign done      = (state == DONE);

    always_comb begin
        state_n   = state;
        beat      = 1'b0;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_n   = (length == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (in_valid) begin
                    beat = 1'b1;
                    if (last_beat)
                        state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            len_q         <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            words_written <= '0;
            checksum      <= '0;
        end else begin
            state <= state_n;
            wr_en <= beat;
            if (start_acc) begin
                ptr           <= base_addr;
                len_q         <= length;
                words_written <= '0;
                checksum      <= '0;
            end
            if (beat) begin
                wr_addr       <= ptr;
                wr_data       <= in_data;
                ptr           <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
                words_written <= words_written + CW'(1);
                checksum      <= checksum + in_data;
            end
        end
    end

endmodule

// File: doc/ram_sp_loader.md
# ram_sp_loader

Write-side loader for the generator's single-port sample RAM. It accepts a stream of data words over a valid/ready handshake and writes them to consecutive RAM addresses, starting from a programmed base address, for a programmed length. It drives the RAM write port (`wr_en`, `wr_addr`, `wr_data`), fills the memory that the synchronous-read RAM block later plays out, and reports completion, a word count and a checksum to the control logic.

## Interface
- `DATA_WIDTH`, 8: width of a sample word.
- `ADDR_WIDTH`, 8: RAM address width.
- `RAM_DEPTH`, `1 << ADDR_WIDTH`: number of RAM words; the address pointer wraps modulo this value.

One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled in IDLE only.
- `base_addr`  in  ADDR_WIDTH  first write address; latched on an accepted `start`.
- `length`  in  ADDR_WIDTH+1  number of words to write, 0..RAM_DEPTH; latched on an accepted `start`.
- `abort`  in  1  cancels a load in progress.
- `in_data`  in  DATA_WIDTH  stream data.
- `in_valid`  in  1  stream data valid.
- `in_ready`  out  1  loader can accept a word.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_WIDTH  RAM write address.
- `wr_data`  out  DATA_WIDTH  RAM write data.
- `busy`  out  1  high while in LOAD.
- `done`  out  1  one-cycle pulse when a load completes.
- `words_written`  out  ADDR_WIDTH+1  number of beats accepted in the current or last load.
- `checksum`  out  DATA_WIDTH  sum of accepted words, modulo 2^DATA_WIDTH.

## Operation
- FSM states: IDLE, LOAD, DONE.
- **IDLE**
  - `start` with `length > 0`: latch `base_addr` into the pointer and latch `length`; clear `words_written` and `checksum`; go to LOAD.
  - `start` with `length == 0`: clear the counters and go to DONE. No write occurs.
- **LOAD**
  - `in_ready = (state == LOAD) && !abort` (combinational).
  - A beat is accepted when `in_valid && in_ready`. On each accepted beat:
    - register `wr_en = 1`, `wr_addr = ptr`, `wr_data = in_data`;
    - `ptr <= ptr + 1`, wrapping from RAM_DEPTH-1 to 0;
    - `words_written += 1`;
    - `checksum += in_data`, truncated to DATA_WIDTH.
  - When the accepted beat is beat number `length`, go to DONE.
  - `abort` returns to IDLE on the next edge and has priority over a beat in the same cycle (no beat is accepted). No `done` pulse is produced. Counters hold their partial values.
  - `in_valid` low: wait indefinitely; there is no timeout.
- **DONE**
  - `done = 1` for exactly one cycle, then go to IDLE.
  - `start` is ignored in this state.
- `start` is ignored in LOAD and DONE.
- `words_written` and `checksum` hold their values until the next accepted `start`.
- `wr_en` is low in every cycle without a beat accepted on the previous edge.

## Timing
- Reset values: state IDLE; `in_ready`, `wr_en`, `busy`, `done` = 0; `wr_addr`, `wr_data`, `words_written`, `checksum` = 0.
- Reset asserted mid-load forces IDLE immediately; no `done` pulse is produced.
- `start` at edge E: `busy` and `in_ready` are high from E+1.
- Write latency: a beat accepted at edge N produces `wr_en` high during N..N+1 (one cycle), with `wr_addr`/`wr_data` valid in the same cycle.
- Counters reflect a beat one cycle after the beat is accepted.
- Last beat accepted at edge N:
  - state is DONE and `done` = 1 in cycle N..N+1, coincident with the final `wr_en`;
  - `in_ready` = 0 from N;
  - back in IDLE at N+1.
- Throughput: one word per clock with `in_valid` held high. A load of L words takes L+2 cycles from `start`.
- `length == RAM_DEPTH`: every address is written exactly once, in order base, base+1, … wrapping around to base-1.

## Structure
- Shared package `generator_pkg` holds:
  - FSM state encoding localparams (IDLE=2'd0, LOAD=2'd1, DONE=2'd2);
  - default DATA_WIDTH / ADDR_WIDTH shared with the RAM blocks.
- Single module, no sub-modules. The pointer, beat counter and checksum accumulator are inline registers.
- Instantiated next to the sample RAM; `wr_*` connect to its write port.

## Test plan
- Reset mid-load: assert `rst` in LOAD after 3 beats -> all outputs 0 immediately, state IDLE, no `done`.
- Basic load: `base_addr`=0x10, `length`=4, data 0x01,0x02,0x03,0x04 back-to-back -> writes to 0x10..0x13 one cycle after each beat; `done` coincides with the last `wr_en`; `words_written`=4, `checksum`=0x0A.
- Wrap and backpressure: `base_addr`=0xFE, `length`=4, `in_valid` toggling 1,0,1,0… -> `wr_addr` sequence 0xFE,0xFF,0x00,0x01; one `wr_en` per accepted beat; `checksum` overflow truncates (0xFF+0x02 -> 0x01).
- Zero length: `start` with `length`=0 -> no `wr_en`, `in_ready` stays 0, `done` pulses 2 cycles after `start`, `words_written`=0.
- Abort: `length`=8, assert `abort` after 3 beats with `in_valid` held high -> `in_ready` low in the abort cycle, exactly 3 writes, no `done`, `words_written`=3; a `start` issued during LOAD is ignored.
- Full depth: `length`=256 at `base_addr`=0x80 -> 256 writes covering every address once, `words_written`=256, load takes 258 cycles.
